// File: rtl/bcd_to_binary_seq.sv
// Sequential packed-BCD to unsigned binary converter (reverse double-dabble, one shift per clock).
// start/busy/done handshake; any digit above 9 is flagged through err and gives binary=0.
module bcd_to_binary_seq #(
  parameter int unsigned DIGITS = 3,
  parameter int unsigned BIN_W  = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [4*DIGITS-1:0]   bcd,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [BIN_W-1:0]      binary
);

  localparam int unsigned BCD_W = 4 * DIGITS;
  localparam int unsigned SR_W  = BCD_W + BIN_W;
  localparam int unsigned CNT_W = $clog2(BIN_W + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [SR_W-1:0]    sr_q, sr_d, sr_sh;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               bad_q, bad_d;
  logic               busy_d, done_d, err_d;
  logic [BIN_W-1:0]   binary_d;

  function automatic logic has_bad_digit(input logic [BCD_W-1:0] v);
    logic bad;
    bad = 1'b0;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (v[4*i +: 4] > 4'd9) bad = 1'b1;
    end
    return bad;
  endfunction

  // Next-state, datapath and output decode
  always_comb begin
    state_d  = state_q;
    sr_d     = sr_q;
    cnt_d    = cnt_q;
    bad_d    = bad_q;
    done_d   = 1'b0;
    err_d    = err;
    binary_d = binary;

    // Shift right, then pull every BCD digit that reached 8 or more back down by 3
    sr_sh = sr_q >> 1;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (sr_sh[BIN_W + 4*i +: 4] >= 4'd8) begin
        sr_sh[BIN_W + 4*i +: 4] = sr_sh[BIN_W + 4*i +: 4] - 4'd3;
      end
    end

    unique case (state_q)
      IDLE: begin
        if (start) begin
          if (has_bad_digit(bcd)) begin
            bad_d   = 1'b1;
            state_d = DONE;
          end else begin
            sr_d    = {bcd, {BIN_W{1'b0}}};
            cnt_d   = '0;
            bad_d   = 1'b0;
            state_d = SHIFT;
          end
        end
      end
      SHIFT: begin
        sr_d  = sr_sh;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(BIN_W - 1)) state_d = DONE;
      end
      DONE: begin
        done_d   = 1'b1;
        err_d    = bad_q;
        binary_d = bad_q ? '0 : sr_q[BIN_W-1:0];
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // busy also covers the cycle in which done is presented
    busy_d = (state_d != IDLE) || (state_q == DONE);
  end

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sr_q    <= '0;
      cnt_q   <= '0;
      bad_q   <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
      binary  <= '0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
      bad_q   <= bad_d;
      busy    <= busy_d;
      done    <= done_d;
      err     <= err_d;
      binary  <= binary_d;
    end
  end

endmodule

// File: tb/tb_bcd_to_binary_seq.sv
// Directed self-checking bench for bcd_to_binary_seq (DIGITS=3, BIN_W=10).
module tb_bcd_to_binary_seq;

  logic        clk;
  logic        rst;
  logic        start;
  logic [11:0] bcd;
  logic        busy;
  logic        done;
  logic        err;
  logic [9:0]  binary;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  bcd_to_binary_seq #(.DIGITS(3), .BIN_W(10)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .bcd    (bcd),
    .busy   (busy),
    .done   (done),
    .err    (err),
    .binary (binary)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [11:0] to_bcd(input int v);
    logic [11:0] r;
    r[11:8] = 4'(v / 100);
    r[7:4]  = 4'((v / 10) % 10);
    r[3:0]  = 4'(v % 10);
    return r;
  endfunction

  // Independent forward double-dabble used for the round-trip check
  function automatic logic [11:0] dabble(input logic [9:0] b);
    logic [21:0] s;
    s = {12'd0, b};
    for (int i = 0; i < 10; i++) begin
      for (int d = 0; d < 3; d++) begin
        if (s[10 + 4*d +: 4] >= 4'd5) s[10 + 4*d +: 4] = s[10 + 4*d +: 4] + 4'd3;
      end
      s = s << 1;
    end
    return s[21:10];
  endfunction

  // Drive start for exactly one acceptance edge; DUT assumed idle
  task automatic start_conv(input logic [11:0] v);
    start = 1'b1;
    bcd   = v;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Returns number of edges from the reference edge until done is seen
  task automatic wait_done(input string tag, output int edges);
    edges = 0;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk);
      #1;
      if (done) begin
        edges = n;
        return;
      end
    end
    check_eq({tag, "_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic count_done(input int n, output int pulses, output logic [9:0] last_bin);
    pulses   = 0;
    last_bin = '0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      if (done) begin
        pulses++;
        last_bin = binary;
      end
    end
  endtask

  initial begin
    int          edges;
    int          pulses;
    int          last_cyc;
    logic [9:0]  lb;
    logic [11:0] vb;

    rst   = 1'b1;
    start = 1'b0;
    bcd   = '0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_done", 32'(done), 32'd0);
    check_eq("rst_err", 32'(err), 32'd0);
    check_eq("rst_binary", 32'(binary), 32'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // 255: latency and result
    start_conv(12'h255);
    check_eq("busy_after_accept", 32'(busy), 32'd1);
    wait_done("c255", edges);
    check_eq("c255_latency", 32'(edges), 32'd11);
    check_eq("c255_binary", 32'(binary), 32'd255);
    check_eq("c255_err", 32'(err), 32'd0);
    check_eq("c255_busy", 32'(busy), 32'd1);
    @(posedge clk);
    #1;
    check_eq("c255_done_one_cycle", 32'(done), 32'd0);
    check_eq("c255_binary_held", 32'(binary), 32'd255);
    check_eq("c255_idle_busy", 32'(busy), 32'd0);

    // Reset in the middle of a 999 conversion
    start_conv(12'h999);
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_eq("midrst_busy", 32'(busy), 32'd0);
    check_eq("midrst_done", 32'(done), 32'd0);
    check_eq("midrst_binary", 32'(binary), 32'd0);
    check_eq("midrst_err", 32'(err), 32'd0);
    rst = 1'b0;
    count_done(20, pulses, lb);
    check_eq("midrst_no_done", 32'(pulses), 32'd0);

    // Directed values
    start_conv(12'h999);
    wait_done("c999", edges);
    check_eq("c999_binary", 32'(binary), 32'd999);
    start_conv(12'h000);
    wait_done("c000", edges);
    check_eq("c000_binary", 32'(binary), 32'd0);
    start_conv(12'h100);
    wait_done("c100", edges);
    check_eq("c100_binary", 32'(binary), 32'd100);

    // Non-decimal digit
    start_conv(12'h1A3);
    wait_done("c1a3", edges);
    check_eq("c1a3_latency", 32'(edges), 32'd1);
    check_eq("c1a3_err", 32'(err), 32'd1);
    check_eq("c1a3_binary", 32'(binary), 32'd0);
    @(posedge clk);
    #1;
    check_eq("c1a3_err_held", 32'(err), 32'd1);
    start_conv(12'h042);
    wait_done("c042", edges);
    check_eq("c042_err", 32'(err), 32'd0);
    check_eq("c042_binary", 32'(binary), 32'd42);

    // start while busy is ignored
    start_conv(12'h123);
    repeat (2) @(posedge clk);
    #1;
    start = 1'b1;
    bcd   = 12'h500;
    @(posedge clk);
    #1;
    start = 1'b0;
    count_done(30, pulses, lb);
    check_eq("ign_pulses", 32'(pulses), 32'd1);
    check_eq("ign_binary", 32'(lb), 32'd123);

    // Exhaustive sweep with start held high
    bcd   = to_bcd(0);
    start = 1'b1;
    @(posedge clk);
    #1;
    last_cyc = 0;
    for (int v = 0; v < 1000; v++) begin
      vb = bcd;
      wait_done("sweep", edges);
      check_eq("sweep_binary", 32'(binary), 32'(v));
      check_eq("sweep_err", 32'(err), 32'd0);
      check_eq("sweep_roundtrip", 32'(dabble(binary)), 32'(vb));
      if (v > 0) check_eq("sweep_spacing", 32'(cyc - last_cyc), 32'd12);
      last_cyc = cyc;
      bcd = to_bcd((v + 1) % 1000);
    end
    start = 1'b0;
    repeat (15) @(posedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
